// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - opcode constants, operand classes and action-word field offsets for crossbar_v2
package crossbar_pkg;

    localparam int OP_W  = 8;
    localparam int IDX_W = 6;
    localparam int IMM_W = 32;

    // Each field is taken as act[ACT_LEN - <ofs> -: <width>].
    localparam int OP_HI_OFS = 1;
    localparam int A_HI_OFS  = 9;
    localparam int B_HI_OFS  = 15;
    localparam int C_HI_OFS  = 21;

    localparam logic [OP_W-1:0] OP_SET      = 8'h0E;
    localparam logic [OP_W-1:0] OP_PKT0_Z   = 8'h14;
    localparam logic [OP_W-1:0] OP_TERN_PPP = 8'h10;
    localparam logic [OP_W-1:0] OP_TERN_PPI = 8'h11;

    typedef enum logic [2:0] {
        CLS_PP,
        CLS_PI,
        CLS_SET,
        CLS_ZERO,
        CLS_TERN_PPP,
        CLS_TERN_PPI,
        CLS_PASS
    } op_class_e;

    // Ternary opcodes fall back to pass-through when only two operand ports exist.
    function automatic op_class_e op_class(input logic [OP_W-1:0] op, input int num_ops);
        op_class_e cls;
        case (op)
            8'h01, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0B,
            8'h0C, 8'h12, 8'h13, 8'h17, 8'h18:          cls = CLS_PP;
            8'h03, 8'h05, 8'h07, 8'h09, 8'h0A,
            8'h1B, 8'h1D:                               cls = CLS_PI;
            OP_SET:                                     cls = CLS_SET;
            OP_PKT0_Z:                                  cls = CLS_ZERO;
            OP_TERN_PPP: cls = (num_ops == 3) ? CLS_TERN_PPP : CLS_PASS;
            OP_TERN_PPI: cls = (num_ops == 3) ? CLS_TERN_PPI : CLS_PASS;
            default:                                    cls = CLS_PASS;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/crossbar_lane.sv
// rtl/crossbar_lane.sv - per-container action decode and operand mux
module crossbar_lane
    import crossbar_pkg::*;
#(
    parameter int NUM_CONT = 64,
    parameter int CONT_W   = 32,
    parameter int ACT_LEN  = 64,
    parameter int NUM_OPS  = 3,
    parameter int LANE     = 0
) (
    input  logic [NUM_CONT*CONT_W-1:0] conts_i,
    input  logic [ACT_LEN-1:0]         act_word_i,
    output logic [NUM_OPS*CONT_W-1:0]  ops_o,
    output logic                       bad_o
);

    logic [OP_W-1:0]        op;
    logic [IDX_W-1:0]       idx_a, idx_b, idx_c;
    logic [CONT_W-1:0]      imm, own;
    logic [CONT_W-1:0]      cont_a, cont_b, cont_c;
    logic                   bad_a, bad_b, bad_c;
    logic                   tern_off;
    op_class_e              cls;
    logic [2:0][CONT_W-1:0] opv;
    logic                   unused_lane;

    // Out-of-range indices match no container and therefore read as zero.
    function automatic logic [CONT_W-1:0] pick(input logic [NUM_CONT*CONT_W-1:0] all,
                                               input logic [IDX_W-1:0] idx);
        logic [CONT_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CONT; k++) begin
            if (idx == IDX_W'(k)) v = all[k*CONT_W +: CONT_W];
        end
        return v;
    endfunction

    assign op    = act_word_i[ACT_LEN-OP_HI_OFS -: OP_W];
    assign idx_a = act_word_i[ACT_LEN-A_HI_OFS -: IDX_W];
    assign idx_b = act_word_i[ACT_LEN-B_HI_OFS -: IDX_W];
    assign idx_c = act_word_i[ACT_LEN-C_HI_OFS -: IDX_W];
    assign imm   = act_word_i[CONT_W-1:0];
    assign own   = conts_i[LANE*CONT_W +: CONT_W];

    assign cont_a = pick(conts_i, idx_a);
    assign cont_b = pick(conts_i, idx_b);
    assign cont_c = pick(conts_i, idx_c);
    assign bad_a  = int'(idx_a) >= NUM_CONT;
    assign bad_b  = int'(idx_b) >= NUM_CONT;
    assign bad_c  = int'(idx_c) >= NUM_CONT;

    assign cls      = op_class(op, NUM_OPS);
    assign tern_off = (NUM_OPS == 2) && ((op == OP_TERN_PPP) || (op == OP_TERN_PPI));

    // Operand mux per class; only indices a class actually references can flag bad.
    always_comb begin
        opv    = '0;
        opv[0] = own;
        opv[2] = own;
        bad_o  = 1'b0;
        case (cls)
            CLS_PP: begin
                opv[0] = cont_a;
                opv[1] = cont_b;
                bad_o  = bad_a | bad_b;
            end
            CLS_PI: begin
                opv[0] = cont_a;
                opv[1] = imm;
                bad_o  = bad_a;
            end
            CLS_SET: begin
                opv[0] = '0;
                opv[1] = imm;
            end
            CLS_ZERO: begin
                opv[0] = cont_a;
                opv[1] = '0;
                bad_o  = bad_a;
            end
            CLS_TERN_PPP: begin
                opv[0] = cont_a;
                opv[1] = cont_b;
                opv[2] = cont_c;
                bad_o  = bad_a | bad_b | bad_c;
            end
            CLS_TERN_PPI: begin
                opv[0] = cont_a;
                opv[1] = cont_b;
                opv[2] = imm;
                bad_o  = bad_a | bad_b;
            end
            default: begin
                opv[0] = own;
                opv[1] = '0;
                bad_o  = tern_off;
            end
        endcase
    end

    assign ops_o = opv[NUM_OPS-1:0];

    assign unused_lane = ^{act_word_i, opv};

endmodule

// File: rtl/crossbar_v2.sv
// rtl/crossbar_v2.sv - operand crossbar with 1-cycle output register and skid buffer; CROSSBAR_V2_STATS_EN adds counters
module crossbar_v2 #(
    parameter int STAGE_ID = 0,
    parameter int NUM_CONT = 64,
    parameter int CONT_W   = 32,
    parameter int ACT_LEN  = 64,
    parameter int NUM_OPS  = 3,
    parameter int REMAIN_W = 256,
    parameter int PHV_LEN  = NUM_CONT*CONT_W+REMAIN_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PHV_LEN-1:0]                 phv_in,
    input  logic                               phv_in_valid,
    input  logic [ACT_LEN*(NUM_CONT+1)-1:0]    action_in,
    input  logic                               action_in_valid,
    output logic                               ready_out,
    output logic                               alu_in_valid,
    output logic [NUM_OPS*NUM_CONT*CONT_W-1:0] alu_in_op,
    output logic [REMAIN_W-1:0]                phv_remain_data,
    output logic [ACT_LEN*(NUM_CONT+1)-1:0]    action_out,
    input  logic                               ready_in,
    output logic                               err_bad_idx,
    output logic [31:0]                        stat_beats,
    output logic [31:0]                        stat_stalls,
    output logic [31:0]                        stat_bad
);

    localparam int ACT_BUS_W = ACT_LEN*(NUM_CONT+1);
    localparam int OPS_W     = NUM_OPS*NUM_CONT*CONT_W;

    logic [OPS_W-1:0]     lane_ops;
    logic [NUM_CONT-1:0]  lane_bad;
    logic                 beat_bad, accept, out_fire;

    logic                 out_valid_q, out_valid_d;
    logic [OPS_W-1:0]     out_ops_q, out_ops_d;
    logic [REMAIN_W-1:0]  out_rem_q, out_rem_d;
    logic [ACT_BUS_W-1:0] out_act_q, out_act_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [OPS_W-1:0]     skid_ops_q, skid_ops_d;
    logic [REMAIN_W-1:0]  skid_rem_q, skid_rem_d;
    logic [ACT_BUS_W-1:0] skid_act_q, skid_act_d;
    logic                 err_q, err_d;
    logic                 unused_top;

    for (genvar i = 0; i < NUM_CONT; i++) begin : g_lane
        logic [NUM_OPS*CONT_W-1:0] ops;

        crossbar_lane #(
            .NUM_CONT (NUM_CONT),
            .CONT_W   (CONT_W),
            .ACT_LEN  (ACT_LEN),
            .NUM_OPS  (NUM_OPS),
            .LANE     (i)
        ) u_lane (
            .conts_i    (phv_in[PHV_LEN-1:REMAIN_W]),
            .act_word_i (action_in[(i+1)*ACT_LEN +: ACT_LEN]),
            .ops_o      (ops),
            .bad_o      (lane_bad[i])
        );

        for (genvar n = 0; n < NUM_OPS; n++) begin : g_op
            assign lane_ops[(n*NUM_CONT+i)*CONT_W +: CONT_W] = ops[n*CONT_W +: CONT_W];
        end
    end

    assign beat_bad  = |lane_bad;
    assign ready_out = !skid_valid_q;
    assign accept    = phv_in_valid & action_in_valid & ready_out;
    assign out_fire  = out_valid_q & ready_in;

    // Output/skid next state: skid drains first, a stalled output diverts new beats to the skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ops_d    = out_ops_q;
        out_rem_d    = out_rem_q;
        out_act_d    = out_act_q;
        skid_valid_d = skid_valid_q;
        skid_ops_d   = skid_ops_q;
        skid_rem_d   = skid_rem_q;
        skid_act_d   = skid_act_q;
        err_d        = err_q | (accept & beat_bad);
        if (skid_valid_q) begin
            if (ready_in) begin
                out_valid_d  = 1'b1;
                out_ops_d    = skid_ops_q;
                out_rem_d    = skid_rem_q;
                out_act_d    = skid_act_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || ready_in) begin
                out_valid_d = 1'b1;
                out_ops_d   = lane_ops;
                out_rem_d   = phv_in[REMAIN_W-1:0];
                out_act_d   = action_in;
            end else begin
                skid_valid_d = 1'b1;
                skid_ops_d   = lane_ops;
                skid_rem_d   = phv_in[REMAIN_W-1:0];
                skid_act_d   = action_in;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Beat registers and sticky error flag; reset drops any held beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_ops_q    <= '0;
            out_rem_q    <= '0;
            out_act_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_ops_q   <= '0;
            skid_rem_q   <= '0;
            skid_act_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ops_q    <= out_ops_d;
            out_rem_q    <= out_rem_d;
            out_act_q    <= out_act_d;
            skid_valid_q <= skid_valid_d;
            skid_ops_q   <= skid_ops_d;
            skid_rem_q   <= skid_rem_d;
            skid_act_q   <= skid_act_d;
            err_q        <= err_d;
        end
    end

    assign alu_in_valid    = out_valid_q;
    assign alu_in_op       = out_ops_q;
    assign phv_remain_data = out_rem_q;
    assign action_out      = out_act_q;
    assign err_bad_idx     = err_q;

`ifdef CROSSBAR_V2_STATS_EN
    logic [31:0] beats_q, stalls_q, bad_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q  <= '0;
            stalls_q <= '0;
            bad_q    <= '0;
        end else begin
            if (out_fire && (beats_q != '1))                      beats_q  <= beats_q + 32'd1;
            if (out_valid_q && !ready_in && (stalls_q != '1))     stalls_q <= stalls_q + 32'd1;
            if (accept && beat_bad && (bad_q != '1))              bad_q    <= bad_q + 32'd1;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
    assign stat_bad    = bad_q;
`else
    assign stat_beats  = '0;
    assign stat_stalls = '0;
    assign stat_bad    = '0;
`endif

    assign unused_top = ^{32'(STAGE_ID)};

endmodule
